segre_id_operand_stage: RTL

//  Parametrised ID->EX operand stage. It sits between the decoder and EX.
//  It resolves both source operands through a NUM_FWD-channel forwarding network,

---
 rtl/segre_id_operand_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/segre_id_operand_stage.sv
// ID->EX operand stage: resolves rs1/rs2 through a priority forwarding network,
// detects load-use hazards and holds operands in a valid/ready output register.

module segre_id_fwd_resolve #(
  parameter int XLEN     = 32,
  parameter int REG_ADDR = 5,
  parameter int NUM_FWD  = 3
) (
  input  logic [REG_ADDR-1:0]               addr_i,
  input  logic [XLEN-1:0]                   rf_data_i,
  input  logic [NUM_FWD-1:0]                fwd_valid_i,
  input  logic [NUM_FWD-1:0][REG_ADDR-1:0]  fwd_waddr_i,
  input  logic [NUM_FWD-1:0][XLEN-1:0]      fwd_data_i,
  input  logic [NUM_FWD-1:0]                fwd_ready_i,
  output logic [XLEN-1:0]                   val_o,
  output logic                              hz_o
);
  logic found;

  // Channel 0 is the youngest producer; the first match shadows all older ones,
  // even when that youngest match is a load still in flight.
  always_comb begin
    val_o = rf_data_i;
    hz_o  = 1'b0;
    found = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (!found && fwd_valid_i[k] && (fwd_waddr_i[k] == addr_i)) begin
        found = 1'b1;
        if (fwd_ready_i[k]) val_o = fwd_data_i[k];
        else                hz_o  = 1'b1;
      end
    end
    if (addr_i == '0) begin
      val_o = '0;
      hz_o  = 1'b0;
    end
  end
endmodule

module segre_id_operand_stage #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR    = 5,
  parameter int NUM_FWD     = 3,
  parameter int CTRL_W      = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        id_valid_i,
  output logic                        id_ready_o,
  input  logic [REG_ADDR-1:0]         rs1_addr_i,
  input  logic [REG_ADDR-1:0]         rs2_addr_i,
  input  logic                        rs1_used_i,
  input  logic                        rs2_used_i,
  input  logic [XLEN-1:0]             rf_data_a_i,
  input  logic [XLEN-1:0]             rf_data_b_i,
  input  logic [CTRL_W-1:0]           ctrl_i,
  input  logic [NUM_FWD-1:0]          fwd_valid_i,
  input  logic [NUM_FWD*REG_ADDR-1:0] fwd_waddr_i,
  input  logic [NUM_FWD*XLEN-1:0]     fwd_data_i,
  input  logic [NUM_FWD-1:0]          fwd_ready_i,
  output logic                        ex_valid_o,
  input  logic                        ex_ready_i,
  output logic [XLEN-1:0]             op_a_o,
  output logic [XLEN-1:0]             op_b_o,
  output logic [CTRL_W-1:0]           ctrl_o,
  output logic [STALL_CNT_W-1:0]      stall_cnt_o
);
  localparam int NUM_OPS = 2;

  logic [NUM_FWD-1:0][REG_ADDR-1:0] fwd_waddr;
  logic [NUM_FWD-1:0][XLEN-1:0]     fwd_data;
  logic [NUM_OPS-1:0][REG_ADDR-1:0] op_addr;
  logic [NUM_OPS-1:0][XLEN-1:0]     op_rf;
  logic [NUM_OPS-1:0][XLEN-1:0]     op_val;
  logic [NUM_OPS-1:0]               op_hz;
  logic [NUM_OPS-1:0]               op_used;

  assign fwd_waddr = fwd_waddr_i;
  assign fwd_data  = fwd_data_i;
  assign op_addr   = {rs2_addr_i, rs1_addr_i};
  assign op_rf     = {rf_data_b_i, rf_data_a_i};
  assign op_used   = {rs2_used_i, rs1_used_i};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    segre_id_fwd_resolve #(
      .XLEN     (XLEN),
      .REG_ADDR (REG_ADDR),
      .NUM_FWD  (NUM_FWD)
    ) u_res (
      .addr_i      (op_addr[g]),
      .rf_data_i   (op_rf[g]),
      .fwd_valid_i (fwd_valid_i),
      .fwd_waddr_i (fwd_waddr),
      .fwd_data_i  (fwd_data),
      .fwd_ready_i (fwd_ready_i),
      .val_o       (op_val[g]),
      .hz_o        (op_hz[g])
    );
  end

  logic                   ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   out_free, hazard;

  assign out_free   = !ex_valid_q || ex_ready_i;
  assign hazard     = id_valid_i && |(op_used & op_hz);
  assign id_ready_o = id_valid_i && out_free && !hazard && !flush_i;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    ctrl_d      = ctrl_q;
    stall_cnt_d = stall_cnt_q;
    // Flush beats both a drain by EX and a fresh accept from ID.
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (out_free) begin
      ex_valid_d = id_ready_o;
      if (id_ready_o) begin
        op_a_d = op_val[0];
        op_b_d = op_val[1];
        ctrl_d = ctrl_i;
      end
    end
    if (hazard && !flush_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o  = ex_valid_q;
  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;
  assign ctrl_o      = ctrl_q;
  assign stall_cnt_o = stall_cnt_q;
endmodule
